oven_ctrl: RTL and testbench
============================

Name: oven_ctrl

Overview:
- Top-level cooking sequencer for the oven CPLD, clocked from the 50 MHz `clk`.
- Captures the user time selection and loads it into the `timer` block, then runs and pauses the countdown.
- Drives heater, lamp and buzzer from the state, the door switch and the timer timeout.
- Sits between the front-panel buttons and the `timer` / digit-display path.

Parameters:
- BEEP_CYCLES, 25000000, clocks per buzzer on-phase and per off-phase (0.5 s at 50 MHz).
- BEEP_COUNT, 3, number of beeps sounded in DONE.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- btn_start  in  1  start/resume button, synchronous level; rising edge detected internally.
- btn_stop  in  1  stop/cancel button, synchronous level; rising edge detected internally.
- door_open  in  1  door switch, 1 = open.
- time_sel  in  4  requested cook time, 0..15 units.
- timer_timeout  in  1  from `timer`, 1-cycle pulse when the countdown reaches 0.
- timer_load  out  1  1-cycle pulse; `timer` loads set_timer.
- timer_run  out  1  countdown enable to `timer`.
- set_timer  out  4  registered time_sel, captured at start.
- heater  out  1  heating element enable.
- lamp  out  1  cavity lamp.
- buzzer  out  1  buzzer drive.
- state  out  3  current state code, for display/debug.

Behaviour:
- State codes: IDLE=0, LOAD=1, COOK=2, PAUSE=3, DONE=4. Codes 5-7 recover to IDLE on the next clock.
- All outputs are registered and Moore-decoded from the state and beep counters.
- Reset (rst_n=0, async):
  - state=IDLE; set_timer=0; timer_load, timer_run, heater, lamp and buzzer all 0, immediately.
  - Beep counters cleared.
  - Button edge-detect flops reset to 1, so a button held through reset release gives no edge until released and pressed again.
- Edge detect: start_e = btn_start & ~btn_start_q; stop_e likewise for btn_stop.
- IDLE:
  - All outputs 0.
  - start_e & ~door_open & time_sel!=0 -> LOAD, with set_timer <= time_sel in the same edge.
  - Otherwise stay in IDLE; a start with time_sel=0 or the door open is ignored.
- LOAD:
  - timer_load=1 for exactly one cycle -> COOK unconditionally.
  - Latency from the start edge to timer_load high: 1 clock.
- COOK:
  - timer_run=1, heater=1, lamp=1.
  - Priority: timer_timeout -> DONE; else stop_e -> IDLE; else door_open -> PAUSE.
- PAUSE:
  - timer_run=0, heater=0, lamp=1.
  - stop_e -> IDLE.
  - start_e & ~door_open -> COOK; resume without reload, no timer_load pulse.
  - Closing the door alone does not resume.
  - A start_e while the door is still open is ignored.
- DONE:
  - heater=0, timer_run=0, lamp=1.
  - Buzzer pattern: on for BEEP_CYCLES, off for BEEP_CYCLES, repeated BEEP_COUNT times, starting the cycle after DONE is entered.
  - After the last off-phase -> IDLE. Total DONE time = 2*BEEP_COUNT*BEEP_CYCLES clocks.
  - stop_e or door_open -> IDLE early; buzzer 0 in the next cycle.
- timer_timeout outside COOK is ignored.
- set_timer holds its value until the next accepted start.
- Counter widths:
  - Phase counter: clog2(BEEP_CYCLES) bits; wraps to 0 at the end of each phase.
  - Beep counter: clog2(2*BEEP_COUNT) bits; no overflow permitted.
- Reset mid-operation (any state): timer_run and heater drop asynchronously; resuming needs a new start.

Test Plan (bench sets BEEP_CYCLES=4, BEEP_COUNT=2):
1. Reset; time_sel=13; pulse btn_start -> LOAD 1 cycle with timer_load=1 and set_timer=13, then COOK with heater=1, timer_run=1, lamp=1, state=2.
2. In COOK, door_open=1 -> PAUSE with heater=0, timer_run=0, lamp=1. Door closed alone -> stays in PAUSE. Pulse btn_start -> COOK, no timer_load pulse.
3. In COOK, pulse timer_timeout -> DONE: buzzer 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0, then IDLE with all outputs 0.
4. time_sel=0 + start, or door_open=1 + start, in IDLE -> stays IDLE, timer_load never asserted, set_timer unchanged.
5. In COOK, timer_timeout and btn_stop edge in the same cycle -> DONE. A btn_stop edge during the first buzzer phase -> IDLE, buzzer 0 next cycle.
6. rst_n low mid-COOK -> heater, timer_run and state=0 immediately. Release with btn_start held high -> no start until btn_start goes low then high.

Source files
------------

// File: rtl/oven_ctrl.sv
// Oven cooking sequencer.
// Captures the requested cook time, pulses the timer load, runs/pauses the
// countdown and drives heater, lamp and buzzer. Every output is a registered
// Moore decode of the state (and, for the buzzer, of the beep counters).
module oven_ctrl #(
  parameter int BEEP_CYCLES = 25000000,  // clocks per buzzer on-phase and per off-phase
  parameter int BEEP_COUNT  = 3          // beeps sounded in DONE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       door_open,
  input  logic [3:0] time_sel,
  input  logic       timer_timeout,
  output logic       timer_load,
  output logic       timer_run,
  output logic [3:0] set_timer,
  output logic       heater,
  output logic       lamp,
  output logic       buzzer,
  output logic [2:0] state
);

  localparam int PW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam int BW = ((2 * BEEP_COUNT) > 1) ? $clog2(2 * BEEP_COUNT) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(BEEP_CYCLES - 1);
  localparam logic [BW-1:0] BEEP_LAST  = BW'(2 * BEEP_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_phase;
  logic [PW-1:0]   w_phase_nxt;
  logic [BW-1:0]   r_beep;
  logic [BW-1:0]   w_beep_nxt;
  logic            r_btn_start_q;
  logic            r_btn_stop_q;
  logic            w_start_e;
  logic            w_stop_e;
  logic            w_accept;
  logic            w_done_end;
  logic [3:0]      r_set_timer;
  logic            r_timer_load;
  logic            r_timer_run;
  logic            r_heater;
  logic            r_lamp;
  logic            r_buzzer;

  // Rising-edge detection on the two buttons.
  assign w_start_e  = btn_start & ~r_btn_start_q;
  assign w_stop_e   = btn_stop  & ~r_btn_stop_q;
  assign w_accept   = w_start_e & ~door_open & (time_sel != 4'd0);
  assign w_done_end = (r_beep == BEEP_LAST) && (r_phase == PHASE_LAST);

  // Next-state decode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_COOK;
      S_COOK: begin
        if (timer_timeout)  w_state_nxt = S_DONE;
        else if (w_stop_e)  w_state_nxt = S_IDLE;
        else if (door_open) w_state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (w_stop_e)                    w_state_nxt = S_IDLE;
        else if (w_start_e & ~door_open) w_state_nxt = S_COOK;
      end
      S_DONE: begin
        if (w_stop_e | door_open) w_state_nxt = S_IDLE;
        else if (w_done_end)      w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;  // codes 5-7 recover
    endcase
  end

  // Beep phase/count sequencing; both counters sit at 0 outside DONE.
  always_comb begin
    w_phase_nxt = '0;
    w_beep_nxt  = '0;
    if (r_state == S_DONE) begin
      if (r_phase == PHASE_LAST) begin
        w_phase_nxt = '0;
        w_beep_nxt  = (r_beep == BEEP_LAST) ? '0 : r_beep + 1'b1;
      end else begin
        w_phase_nxt = r_phase + 1'b1;
        w_beep_nxt  = r_beep;
      end
    end
  end

  // State, counters, button history and time capture.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_phase       <= '0;
      r_beep        <= '0;
      r_btn_start_q <= 1'b1;  // a button held through reset yields no edge
      r_btn_stop_q  <= 1'b1;
      r_set_timer   <= 4'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_beep        <= w_beep_nxt;
      r_btn_start_q <= btn_start;
      r_btn_stop_q  <= btn_stop;
      if ((r_state == S_IDLE) && w_accept) r_set_timer <= time_sel;
    end
  end

  // Registered Moore outputs, decoded from the state being entered so they
  // line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer_load <= 1'b0;
      r_timer_run  <= 1'b0;
      r_heater     <= 1'b0;
      r_lamp       <= 1'b0;
      r_buzzer     <= 1'b0;
    end else begin
      r_timer_load <= (w_state_nxt == S_LOAD);
      r_timer_run  <= (w_state_nxt == S_COOK);
      r_heater     <= (w_state_nxt == S_COOK);
      r_lamp       <= (w_state_nxt == S_COOK) || (w_state_nxt == S_PAUSE) ||
                      (w_state_nxt == S_DONE);
      r_buzzer     <= (w_state_nxt == S_DONE) && !w_beep_nxt[0];
    end
  end

  assign timer_load = r_timer_load;
  assign timer_run  = r_timer_run;
  assign set_timer  = r_set_timer;
  assign heater     = r_heater;
  assign lamp       = r_lamp;
  assign buzzer     = r_buzzer;
  assign state      = r_state;

endmodule

// File: tb/tb_oven_ctrl.sv
// Self-checking bench for oven_ctrl: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_oven_ctrl;

  localparam int BC = 4;  // BEEP_CYCLES
  localparam int BN = 2;  // BEEP_COUNT

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start;
  logic       btn_stop;
  logic       door_open;
  logic [3:0] time_sel;
  logic       timer_timeout;
  logic       timer_load;
  logic       timer_run;
  logic [3:0] set_timer;
  logic       heater;
  logic       lamp;
  logic       buzzer;
  logic [2:0] state;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: state code, captured time, cycles spent in DONE, and
  // the previous button levels.
  int m_state;
  int m_set;
  int m_done_t;
  bit m_pstart;
  bit m_pstop;

  oven_ctrl #(.BEEP_CYCLES(BC), .BEEP_COUNT(BN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_start     (btn_start),
    .btn_stop      (btn_stop),
    .door_open     (door_open),
    .time_sel      (time_sel),
    .timer_timeout (timer_timeout),
    .timer_load    (timer_load),
    .timer_run     (timer_run),
    .set_timer     (set_timer),
    .heater        (heater),
    .lamp          (lamp),
    .buzzer        (buzzer),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_set    = 0;
    m_done_t = 0;
    m_pstart = 1'b1;
    m_pstop  = 1'b1;
  endtask

  // One clock of the oven rules, using the inputs present at the edge.
  task automatic model_step();
    bit se;
    bit pe;
    se = btn_start && !m_pstart;
    pe = btn_stop && !m_pstop;
    m_pstart = btn_start;
    m_pstop  = btn_stop;
    case (m_state)
      0: if (se && !door_open && time_sel != 0) begin
           m_state = 1;
           m_set   = int'(time_sel);
         end
      1: m_state = 2;
      2: if (timer_timeout) begin
           m_state  = 4;
           m_done_t = 0;
         end else if (pe) m_state = 0;
         else if (door_open) m_state = 3;
      3: if (pe) m_state = 0;
         else if (se && !door_open) m_state = 2;
      4: if (pe || door_open) m_state = 0;
         else if (m_done_t + 1 >= 2 * BN * BC) m_state = 0;
         else m_done_t++;
      default: m_state = 0;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    bit e_buz;
    e_buz = (m_state == 4) && (((m_done_t / BC) % 2) == 0);
    check({tag, ".state"},      32'(state),      32'(m_state));
    check({tag, ".set_timer"},  32'(set_timer),  32'(m_set));
    check({tag, ".timer_load"}, 32'(timer_load), 32'(m_state == 1));
    check({tag, ".timer_run"},  32'(timer_run),  32'(m_state == 2));
    check({tag, ".heater"},     32'(heater),     32'(m_state == 2));
    check({tag, ".lamp"},       32'(lamp),       32'(m_state >= 2 && m_state <= 4));
    check({tag, ".buzzer"},     32'(buzzer),     32'(e_buz));
  endtask

  // Advance one clock; model updates at the edge, outputs sampled 1 ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  logic [15:0] buz_pat;

  initial begin
    rst_n = 1'b0; btn_start = 1'b0; btn_stop = 1'b0; door_open = 1'b0;
    time_sel = 4'd0; timer_timeout = 1'b0;
    model_reset();
    #3;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick("idle");

    // 1: start with 13
    time_sel = 4'd13; btn_start = 1'b1;
    tick("t1_load");
    check("t1_load_pulse", 32'(timer_load), 32'd1);
    check("t1_set13", 32'(set_timer), 32'd13);
    btn_start = 1'b0;
    tick("t1_cook");
    check("t1_cook_state", 32'(state), 32'd2);
    check("t1_load_gone", 32'(timer_load), 32'd0);

    // 2: door pause / resume
    door_open = 1'b1;
    tick("t2_pause");
    check("t2_pause_state", 32'(state), 32'd3);
    check("t2_heater_off", 32'(heater), 32'd0);
    door_open = 1'b0;
    tick("t2_closed");
    tick("t2_closed2");
    check("t2_still_pause", 32'(state), 32'd3);
    btn_start = 1'b1;
    tick("t2_resume");
    check("t2_resume_cook", 32'(state), 32'd2);
    check("t2_no_reload", 32'(timer_load), 32'd0);
    btn_start = 1'b0;
    tick("t2_cook");

    // 3: timeout -> DONE with full beep pattern
    buz_pat = 16'b1111_0000_1111_0000;
    timer_timeout = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick("t3_done");
      timer_timeout = 1'b0;
      check($sformatf("t3_buz%0d", i), 32'(buzzer), 32'(buz_pat[15-i]));
      check($sformatf("t3_st%0d", i), 32'(state), 32'd4);
    end
    tick("t3_idle");
    check("t3_back_idle", 32'(state), 32'd0);
    check("t3_lamp_off", 32'(lamp), 32'd0);

    // 4: rejected starts
    time_sel = 4'd0; btn_start = 1'b1;
    tick("t4_zero");
    btn_start = 1'b0;
    tick("t4_zero2");
    check("t4_zero_idle", 32'(state), 32'd0);
    check("t4_zero_set", 32'(set_timer), 32'd13);
    door_open = 1'b1; time_sel = 4'd5; btn_start = 1'b1;
    tick("t4_door");
    check("t4_door_noload", 32'(timer_load), 32'd0);
    btn_start = 1'b0;
    tick("t4_door2");
    check("t4_door_set", 32'(set_timer), 32'd13);
    door_open = 1'b0;

    // 5: timeout beats stop; stop during first beep
    time_sel = 4'd7; btn_start = 1'b1;
    tick("t5_load");
    btn_start = 1'b0;
    tick("t5_cook");
    timer_timeout = 1'b1; btn_stop = 1'b1;
    tick("t5_done");
    check("t5_timeout_wins", 32'(state), 32'd4);
    timer_timeout = 1'b0; btn_stop = 1'b0;
    tick("t5_beep");
    check("t5_beep_on", 32'(buzzer), 32'd1);
    btn_stop = 1'b1;
    tick("t5_stop");
    check("t5_stop_idle", 32'(state), 32'd0);
    check("t5_buz_off", 32'(buzzer), 32'd0);
    btn_stop = 1'b0;
    tick("t5_idle");

    // 6: reset mid-COOK, start held through release
    time_sel = 4'd9; btn_start = 1'b1;
    tick("t6_load");
    btn_start = 1'b0;
    tick("t6_cook");
    #2;
    rst_n = 1'b0; btn_start = 1'b1;
    model_reset();
    #1;
    check("t6_rst_heater", 32'(heater), 32'd0);
    check("t6_rst_run", 32'(timer_run), 32'd0);
    check("t6_rst_state", 32'(state), 32'd0);
    check_outputs("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick("t6_held");
    tick("t6_held2");
    check("t6_no_start", 32'(state), 32'd0);
    btn_start = 1'b0;
    tick("t6_rel");
    btn_start = 1'b1;
    tick("t6_press");
    check("t6_restart", 32'(state), 32'd1);
    check("t6_set9", 32'(set_timer), 32'd9);
    btn_start = 1'b0;
    tick("t6_cook2");

    // Random phase
    for (int i = 0; i < 400; i++) begin
      btn_start     = ($urandom_range(0, 3) == 0);
      btn_stop      = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) == 0) door_open = ~door_open;
      time_sel      = 4'($urandom_range(0, 15));
      timer_timeout = ($urandom_range(0, 7) == 0);
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
